arbiter_match_ctrl: RTL and testbench
=====================================

Name: arbiter_match_ctrl

Overview:
Match-level controller for the two-player reaction game. It sequences the countdown and winner-display blocks over multiple rounds and arbitrates button presses with false-start detection and round-robin tie-breaking. It also keeps per-player scores and declares a match champion at WIN_SCORE. It replaces the single-round FSM and drives the same cd/w/leds control nets.

Parameters:
WIN_SCORE, 3, points needed to win the match (1..7)
SCORE_W, 3, width of each score counter
RACE_TIMEOUT, 4000, clk cycles allowed in RACE before the round is voided (4 s at 1 kHz)
SYNC_STAGES, 2, flops in each button synchronizer (>=2)

Ports:
clk  input  1  system clock (io_in[0])
rst_in_n  input  1  asynchronous active-low reset, applied directly to all flops
req1  input  1  player 1 button, active-high, asynchronous
req2  input  1  player 2 button, active-high, asynchronous
cd_done  input  1  countdown finished; level, held until cd_rst asserts
w_done  input  1  winner display finished; level, held until w_rst asserts
gnt1_out  output  1  player 1 won the round or match
gnt2_out  output  1  player 2 won the round or match
cd_rst_out  output  1  active-high hold/reset of the countdown block
w_rst_out  output  1  active-high hold/reset of the winner block
leds_rst_out  output  1  force LED register to 0
leds_sel_out  output  1  0 = countdown LEDs, 1 = winner LEDs
foul_out  output  2  bit i set = player i+1 false-started this round
score1_out  output  SCORE_W  player 1 score
score2_out  output  SCORE_W  player 2 score
match_over_out  output  1  champion decided

Behaviour:
- Reset values: cd_rst=1, w_rst=1, leds_rst=1, leds_sel=0, gnt=00, foul=00, scores=0, match_over=0, priority pointer=player 1, state=ARM. All outputs are registered.
- Each req passes through a SYNC_STAGES synchronizer, then a rising-edge detector. A press event pN is a 1-cycle pulse, SYNC_STAGES+1 cycles after the pin rises.
- ARM: cd_rst=1, w_rst=1, leds_rst=1. When both synced reqs are low, go to COUNT on the next cycle.
- COUNT: cd_rst=0, leds_sel=0, leds_rst=0.
  - cd_done=1 -> RACE, timeout counter cleared.
  - p1 only -> foul_out=01; gnt2 asserted; SHOW.
  - p2 only -> foul_out=10; gnt1 asserted; SHOW.
  - p1 and p2 in the same cycle -> no point; ARM.
  - cd_done has precedence over a same-cycle press.
- RACE: cd_rst=0 (countdown LEDs stay at the final pattern).
  - p1 only -> gnt1; SHOW.
  - p2 only -> gnt2; SHOW.
  - Both in the same cycle -> grant the priority pointer's player, then toggle the pointer. The pointer changes only on ties.
  - Counter reaches RACE_TIMEOUT-1 -> void round; ARM.
- SHOW: exactly one gnt held; w_rst=0, leds_sel=1, cd_rst=1. Winner's score increments on SHOW entry, saturating at WIN_SCORE. When w_done=1 -> CHECK.
- CHECK (1 cycle): gnt cleared, foul cleared, w_rst=1.
  - Either score == WIN_SCORE -> MATCH_END.
  - Else -> ARM.
- MATCH_END: match_over=1; champion's gnt held; leds_rst=1; cd_rst=w_rst=1. Presses are ignored except both synced reqs high in the same cycle: scores cleared, pointer reset to player 1, match_over cleared, ARM.
- Button held through the ARM->COUNT exit produces no event (edge-based). Button bounce after a decision is ignored until the next ARM.
- rst_in_n low at any time returns to the reset values immediately, including mid-SHOW and mid-RACE.
- Output changes land 1 cycle after the deciding event. Press pin to gnt latency = SYNC_STAGES+2 cycles.

Decomposition:
- Shared include arbiter_game_defs.vh: state encodings (ARM, COUNT, RACE, SHOW, CHECK, MATCH_END), player ID constants P1=0 and P2=1, foul bit positions.
- One sub-module button_sync_edge (SYNC_STAGES param; outputs the synced level and the press pulse), instantiated twice.
- FSM, score counters, timeout counter and priority pointer live in the top module.

Test Plan:
- Reset, release both; cd_done rises; press req1 -> gnt1=1, score1=1, leds_sel=1 after SYNC_STAGES+2 cycles; w_done -> gnt1=0, back to ARM.
- req2 pressed during COUNT -> foul_out=10, gnt1=1, score1=1, score2=0.
- req1 and req2 rising together in RACE, three times -> winners P1, P2, P1 (pointer toggles on each tie).
- Both pressed the same cycle in COUNT -> no grant, scores unchanged, ARM. No press for 4000 cycles in RACE -> ARM, scores unchanged.
- P2 wins 3 rounds -> score2=3, match_over=1, gnt2 held; both buttons held -> scores 0, match_over=0, ARM.
- rst_in_n pulsed low mid-SHOW -> all outputs at reset values in the same cycle, scores 0.

Source files
------------

// File: rtl/arbiter_match_ctrl_pkg.sv
// Shared definitions for the match controller: FSM states, player IDs and foul bit positions.
package arbiter_match_ctrl_pkg;

    typedef enum logic [2:0] {
        StArm,
        StCount,
        StRace,
        StShow,
        StCheck,
        StMatchEnd
    } state_e;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] FoulP1 = 2'b01;
    localparam logic [1:0] FoulP2 = 2'b10;

    // Grant vector is {gnt2, gnt1}.
    function automatic logic [1:0] gnt_of(input logic player);
        return (player == P2) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Multi-flop synchronizer for an asynchronous button, with a registered rising-edge pulse.
module button_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_in_n,
    input  logic i_req,
    output logic o_level,
    output logic o_press
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_press;

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_sync  <= '0;
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_req};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_press <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_press = r_press;

endmodule

// File: rtl/arbiter_match_ctrl.sv
// Multi-round match controller: sequences countdown/winner blocks, arbitrates presses,
// flags false starts, keeps scores and declares a champion.
module arbiter_match_ctrl
    import arbiter_match_ctrl_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 3,
    parameter int unsigned SCORE_W      = 3,
    parameter int unsigned RACE_TIMEOUT = 4000,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst_in_n,
    input  logic               req1,
    input  logic               req2,
    input  logic               cd_done,
    input  logic               w_done,
    output logic               gnt1_out,
    output logic               gnt2_out,
    output logic               cd_rst_out,
    output logic               w_rst_out,
    output logic               leds_rst_out,
    output logic               leds_sel_out,
    output logic [1:0]         foul_out,
    output logic [SCORE_W-1:0] score1_out,
    output logic [SCORE_W-1:0] score2_out,
    output logic               match_over_out
);

    localparam int unsigned        TimerW      = $clog2(RACE_TIMEOUT);
    localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(RACE_TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] WinVal      = SCORE_W'(WIN_SCORE);

    logic w_lvl1, w_press1, w_lvl2, w_press2;
    logic w_win_valid, w_winner;

    state_e             r_state;
    logic [TimerW-1:0]  r_timer;
    logic               r_ptr;
    logic [SCORE_W-1:0] r_score1, r_score2;
    logic [1:0]         r_gnt, r_foul;
    logic               r_cd_rst, r_w_rst, r_leds_rst, r_leds_sel, r_match_over;

    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .i_req    (req1),
        .o_level  (w_lvl1),
        .o_press  (w_press1)
    );

    button_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
        .clk      (clk),
        .rst_in_n (rst_in_n),
        .i_req    (req2),
        .o_level  (w_lvl2),
        .o_press  (w_press2)
    );

    // Round decision: a lone press in COUNT is a foul that hands the point to the opponent.
    always_comb begin
        w_win_valid = 1'b0;
        w_winner    = P1;
        if (r_state == StCount) begin
            if (!cd_done && (w_press1 ^ w_press2)) begin
                w_win_valid = 1'b1;
                w_winner    = w_press1 ? P2 : P1;
            end
        end else if (r_state == StRace) begin
            if (w_press1 && w_press2) begin
                w_win_valid = 1'b1;
                w_winner    = r_ptr;
            end else if (w_press1 || w_press2) begin
                w_win_valid = 1'b1;
                w_winner    = w_press2 ? P2 : P1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state      <= StArm;
            r_timer      <= '0;
            r_ptr        <= P1;
            r_score1     <= '0;
            r_score2     <= '0;
            r_gnt        <= 2'b00;
            r_foul       <= 2'b00;
            r_cd_rst     <= 1'b1;
            r_w_rst      <= 1'b1;
            r_leds_rst   <= 1'b1;
            r_leds_sel   <= 1'b0;
            r_match_over <= 1'b0;
        end else if (w_win_valid) begin
            r_state    <= StShow;
            r_gnt      <= gnt_of(w_winner);
            r_cd_rst   <= 1'b1;
            r_w_rst    <= 1'b0;
            r_leds_sel <= 1'b1;
            if (w_winner == P1 && r_score1 < WinVal) r_score1 <= r_score1 + 1'b1;
            if (w_winner == P2 && r_score2 < WinVal) r_score2 <= r_score2 + 1'b1;
            if (r_state == StCount) r_foul <= w_press1 ? FoulP1 : FoulP2;
            if (r_state == StRace && w_press1 && w_press2) r_ptr <= ~r_ptr;
        end else begin
            unique case (r_state)
                StArm: if (!w_lvl1 && !w_lvl2) begin
                    r_state    <= StCount;
                    r_cd_rst   <= 1'b0;
                    r_leds_rst <= 1'b0;
                    r_leds_sel <= 1'b0;
                end
                StCount: if (cd_done) begin
                    r_state <= StRace;
                    r_timer <= '0;
                end else if (w_press1 && w_press2) begin
                    r_state    <= StArm;
                    r_cd_rst   <= 1'b1;
                    r_leds_rst <= 1'b1;
                end
                StRace: if (r_timer == TimeoutLast) begin
                    r_state    <= StArm;
                    r_cd_rst   <= 1'b1;
                    r_leds_rst <= 1'b1;
                end else begin
                    r_timer <= r_timer + 1'b1;
                end
                StShow: if (w_done) begin
                    r_state <= StCheck;
                    r_gnt   <= 2'b00;
                    r_foul  <= 2'b00;
                    r_w_rst <= 1'b1;
                end
                StCheck: begin
                    r_leds_rst <= 1'b1;
                    if (r_score1 == WinVal || r_score2 == WinVal) begin
                        r_state      <= StMatchEnd;
                        r_match_over <= 1'b1;
                        r_gnt        <= gnt_of((r_score2 == WinVal) ? P2 : P1);
                    end else begin
                        r_state <= StArm;
                    end
                end
                StMatchEnd: if (w_lvl1 && w_lvl2) begin
                    r_state      <= StArm;
                    r_score1     <= '0;
                    r_score2     <= '0;
                    r_ptr        <= P1;
                    r_match_over <= 1'b0;
                    r_gnt        <= 2'b00;
                end
                default: r_state <= StArm;
            endcase
        end
    end

    assign gnt1_out       = r_gnt[0];
    assign gnt2_out       = r_gnt[1];
    assign cd_rst_out     = r_cd_rst;
    assign w_rst_out      = r_w_rst;
    assign leds_rst_out   = r_leds_rst;
    assign leds_sel_out   = r_leds_sel;
    assign foul_out       = r_foul;
    assign score1_out     = r_score1;
    assign score2_out     = r_score2;
    assign match_over_out = r_match_over;

endmodule

// File: tb/tb_arbiter_match_ctrl.sv
// Randomized round-by-round bench for arbiter_match_ctrl against a score/pointer model.
module tb_arbiter_match_ctrl;

    localparam int WinScore    = 3;
    localparam int ScoreW      = 3;
    localparam int RaceTimeout = 4000;
    localparam int SyncStages  = 2;

    localparam int KNormal = 0;
    localparam int KFoul   = 1;
    localparam int KTie    = 2;
    localparam int KVoid   = 3;

    logic              clk = 1'b0;
    logic              rst_in_n, req1, req2, cd_done, w_done;
    logic              gnt1_out, gnt2_out, cd_rst_out, w_rst_out, leds_rst_out, leds_sel_out;
    logic [1:0]        foul_out;
    logic [ScoreW-1:0] score1_out, score2_out;
    logic              match_over_out;

    int errors = 0;
    int checks = 0;
    int m_s1 = 0;
    int m_s2 = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    arbiter_match_ctrl #(
        .WIN_SCORE    (WinScore),
        .SCORE_W      (ScoreW),
        .RACE_TIMEOUT (RaceTimeout),
        .SYNC_STAGES  (SyncStages)
    ) dut (
        .clk            (clk),
        .rst_in_n       (rst_in_n),
        .req1           (req1),
        .req2           (req2),
        .cd_done        (cd_done),
        .w_done         (w_done),
        .gnt1_out       (gnt1_out),
        .gnt2_out       (gnt2_out),
        .cd_rst_out     (cd_rst_out),
        .w_rst_out      (w_rst_out),
        .leds_rst_out   (leds_rst_out),
        .leds_sel_out   (leds_sel_out),
        .foul_out       (foul_out),
        .score1_out     (score1_out),
        .score2_out     (score2_out),
        .match_over_out (match_over_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_scores(input string tag);
        chk({tag, "_s1"}, score1_out, m_s1);
        chk({tag, "_s2"}, score2_out, m_s2);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cd_rst"}, cd_rst_out, 1);
        chk({tag, "_w_rst"}, w_rst_out, 1);
        chk({tag, "_leds_rst"}, leds_rst_out, 1);
        chk({tag, "_leds_sel"}, leds_sel_out, 0);
        chk({tag, "_gnt"}, {gnt2_out, gnt1_out}, 0);
        chk({tag, "_foul"}, foul_out, 0);
        chk({tag, "_s1"}, score1_out, 0);
        chk({tag, "_s2"}, score2_out, 0);
        chk({tag, "_match_over"}, match_over_out, 0);
    endtask

    // Bounded wait for the countdown to be released; an expired bound shows up as a failure.
    task automatic wait_count(input string tag);
        int n;
        n = 0;
        while (cd_rst_out !== 1'b0 && n < 64) begin
            step(1);
            n++;
        end
        chk(tag, cd_rst_out, 0);
    endtask

    task automatic play_round(input int kind, input int who);
        int         win;
        logic [1:0] exp_foul;
        int         exp_gnt;
        exp_foul = 2'b00;
        wait_count("count_entry");
        chk("count_leds_sel", leds_sel_out, 0);
        chk("count_leds_rst", leds_rst_out, 0);
        step($urandom_range(0, 5));
        if (kind == KNormal || kind == KTie) begin
            cd_done = 1'b1;
            step(1 + $urandom_range(0, 8));
        end
        if (kind == KTie || kind == KVoid) begin
            req1 = 1'b1;
            req2 = 1'b1;
        end else if (who == 0) begin
            req1 = 1'b1;
        end else begin
            req2 = 1'b1;
        end
        step(SyncStages + 1);
        chk("gnt_not_early", {gnt2_out, gnt1_out}, 0);
        step(1);
        case (kind)
            KNormal: win = who;
            KFoul: begin
                win      = 1 - who;
                exp_foul = (who == 0) ? 2'b01 : 2'b10;
            end
            KTie: begin
                win   = m_ptr;
                m_ptr = 1 - m_ptr;
            end
            default: win = -1;
        endcase
        if (win < 0) begin
            chk("void_gnt", {gnt2_out, gnt1_out}, 0);
            chk("void_cd_rst", cd_rst_out, 1);
            chk_scores("void");
            req1 = 1'b0;
            req2 = 1'b0;
            return;
        end
        if (win == 0 && m_s1 < WinScore) m_s1++;
        if (win == 1 && m_s2 < WinScore) m_s2++;
        exp_gnt = (win == 0) ? 1 : 2;
        chk("show_gnt", {gnt2_out, gnt1_out}, exp_gnt);
        chk("show_foul", foul_out, exp_foul);
        chk_scores("show");
        chk("show_leds_sel", leds_sel_out, 1);
        chk("show_cd_rst", cd_rst_out, 1);
        chk("show_w_rst", w_rst_out, 0);
        req1    = 1'b0;
        req2    = 1'b0;
        cd_done = 1'b0;
        if ($urandom_range(0, 1) == 1) begin
            req1 = 1'b1;
            req2 = 1'b1;
            step(1);
            req1 = 1'b0;
            req2 = 1'b0;
        end
        step(SyncStages + 3);
        chk("show_hold_gnt", {gnt2_out, gnt1_out}, exp_gnt);
        w_done = 1'b1;
        step(1);
        chk("check_gnt", {gnt2_out, gnt1_out}, 0);
        chk("check_foul", foul_out, 0);
        chk("check_w_rst", w_rst_out, 1);
        w_done = 1'b0;
        step(1);
        if (m_s1 == WinScore || m_s2 == WinScore) begin
            chk("match_over", match_over_out, 1);
            chk("champion_gnt", {gnt2_out, gnt1_out}, (m_s1 == WinScore) ? 1 : 2);
            chk("match_leds_rst", leds_rst_out, 1);
            req1 = 1'b1;
            req2 = 1'b1;
            step(SyncStages + 1);
            m_s1  = 0;
            m_s2  = 0;
            m_ptr = 0;
            chk("restart_match_over", match_over_out, 0);
            chk_scores("restart");
            req1 = 1'b0;
            req2 = 1'b0;
        end else begin
            chk("no_match_over", match_over_out, 0);
            chk("arm_cd_rst", cd_rst_out, 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in_n = 1'b0;
        req1     = 1'b0;
        req2     = 1'b0;
        cd_done  = 1'b0;
        w_done   = 1'b0;
        step(3);
        chk_reset_vals("reset");
        rst_in_n = 1'b1;
        step(1);

        // Three RACE ties: pointer alternates P1, P2, P1.
        play_round(KTie, 0);
        play_round(KTie, 0);
        play_round(KTie, 0);
        play_round(KVoid, 0);

        // Race timeout voids the round.
        wait_count("to_count");
        cd_done = 1'b1;
        step(1);
        step(RaceTimeout - 1);
        chk("to_still_race", cd_rst_out, 0);
        step(1);
        chk("to_arm", cd_rst_out, 1);
        chk("to_gnt", {gnt2_out, gnt1_out}, 0);
        chk_scores("to");
        cd_done = 1'b0;

        play_round(KNormal, 0);
        play_round(KFoul, 1);
        for (int i = 0; i < 3; i++) play_round(KNormal, 1);

        for (int i = 0; i < 24; i++) begin
            play_round(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of SHOW.
        wait_count("rst_count");
        cd_done = 1'b1;
        step(2);
        req2 = 1'b1;
        step(SyncStages + 2);
        chk("pre_reset_gnt", {gnt2_out, gnt1_out}, 2);
        rst_in_n = 1'b0;
        #1;
        chk_reset_vals("mid_show_reset");
        req2    = 1'b0;
        cd_done = 1'b0;
        step(2);
        rst_in_n = 1'b1;
        step(2);
        chk("post_reset_gnt", {gnt2_out, gnt1_out}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
